// File: rtl/tis_run_ctl.sv
// Run/step/halt sequencer for the TIS core grid: button edges -> registered core_en/core_rst,
// executed-cycle counter, and deadlock stop when every core stays stalled for DEADLOCK_CYCLES.
module tis_run_ctl #(
    parameter int NCORES          = 12,
    parameter int DEADLOCK_CYCLES = 16,
    parameter int CNT_W           = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_btn,
    input  logic              step_btn,
    input  logic              halt_btn,
    input  logic              restart_btn,
    input  logic [NCORES-1:0] core_stall,
    output logic              core_en,
    output logic              core_rst,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              deadlock
);

    localparam int SW = $clog2(DEADLOCK_CYCLES);
    localparam logic [SW-1:0] STALL_LAST = SW'(DEADLOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        HALTED     = 2'b00,
        RUNNING    = 2'b01,
        STEPPING   = 2'b10,
        DEADLOCKED = 2'b11
    } state_t;

    state_t        st;
    logic          run_q, step_q, halt_q, restart_q;
    logic [1:0]    rst_hold;
    logic [SW-1:0] stall_cnt;

    logic hold, run_req, step_req, halt_req, restart_req, stalled, dl_hit;

    // Requests are accepted again on the edge where rst_hold falls from 1 to 0,
    // which is the same edge that drops core_rst.
    always_comb begin
        hold        = rst_hold[1];
        run_req     = run_btn     & ~run_q     & ~hold;
        step_req    = step_btn    & ~step_q    & ~hold;
        halt_req    = halt_btn    & ~halt_q    & ~hold;
        restart_req = restart_btn & ~restart_q & ~hold;
        stalled     = core_en & (&core_stall);
        dl_hit      = stalled && (stall_cnt == STALL_LAST);
    end

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= 1'b1;
            step_q    <= 1'b1;
            halt_q    <= 1'b1;
            restart_q <= 1'b1;
            rst_hold  <= 2'd2;
            core_rst  <= 1'b1;
            core_en   <= 1'b0;
            st        <= HALTED;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            deadlock  <= 1'b0;
        end else begin
            run_q     <= run_btn;
            step_q    <= step_btn;
            halt_q    <= halt_btn;
            restart_q <= restart_btn;
            if (restart_req) begin
                rst_hold  <= 2'd2;
                core_rst  <= 1'b1;
                core_en   <= 1'b0;
                st        <= HALTED;
                cycle_cnt <= '0;
                stall_cnt <= '0;
                deadlock  <= 1'b0;
            end else begin
                if (rst_hold != 2'd0)
                    rst_hold <= rst_hold - 2'd1;
                core_rst <= rst_hold[1];
                if (core_en && (cycle_cnt != {CNT_W{1'b1}}))
                    cycle_cnt <= cycle_cnt + 1'b1;
                stall_cnt <= stalled ? stall_cnt + 1'b1 : '0;
                case (st)
                    // A halt request outranks run/step even though it does nothing here.
                    HALTED: begin
                        if (!halt_req && step_req) begin
                            st      <= STEPPING;
                            core_en <= 1'b1;
                        end else if (!halt_req && run_req) begin
                            st      <= RUNNING;
                            core_en <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        if (halt_req) begin
                            st      <= HALTED;
                            core_en <= 1'b0;
                        end else if (dl_hit) begin
                            st       <= DEADLOCKED;
                            core_en  <= 1'b0;
                            deadlock <= 1'b1;
                        end
                    end
                    STEPPING: begin
                        st      <= HALTED;
                        core_en <= 1'b0;
                    end
                    DEADLOCKED: begin
                        if (halt_req) begin
                            st       <= HALTED;
                            deadlock <= 1'b0;
                        end
                    end
                    default: begin
                        st      <= HALTED;
                        core_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tis_run_ctl.sv
// Directed bench for tis_run_ctl; a second instance with a 4-bit counter shares the stimulus
// so counter saturation can be checked alongside the default configuration.
module tb_tis_run_ctl;

    logic        clk = 1'b0;
    logic        rst, run_btn, step_btn, halt_btn, restart_btn;
    logic [11:0] core_stall;
    logic        core_en, core_rst, deadlock;
    logic [1:0]  state;
    logic [23:0] cycle_cnt;
    logic        s_core_en, s_core_rst, s_deadlock;
    logic [1:0]  s_state;
    logic [3:0]  s_cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    tis_run_ctl #(.NCORES(12), .DEADLOCK_CYCLES(16), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn),
        .halt_btn(halt_btn), .restart_btn(restart_btn), .core_stall(core_stall),
        .core_en(core_en), .core_rst(core_rst), .state(state),
        .cycle_cnt(cycle_cnt), .deadlock(deadlock)
    );

    tis_run_ctl #(.NCORES(12), .DEADLOCK_CYCLES(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn),
        .halt_btn(halt_btn), .restart_btn(restart_btn), .core_stall(core_stall),
        .core_en(s_core_en), .core_rst(s_core_rst), .state(s_state),
        .cycle_cnt(s_cycle_cnt), .deadlock(s_deadlock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Restart from a quiet state; edge k is the first tick.
    task automatic do_restart();
        restart_btn = 1'b1;
        tick(1);
        restart_btn = 1'b0;
        chk("rs_core_rst_k", core_rst, 1);
        chk("rs_cnt_clr", cycle_cnt, 0);
        chk("rs_state", state, 0);
        step_btn = 1'b1;
        tick(1);
        step_btn = 1'b0;
        chk("rs_core_rst_k1", core_rst, 1);
        chk("rs_step_ignored", state, 0);
        chk("rs_en_k1", core_en, 0);
        tick(1);
        chk("rs_core_rst_k2", core_rst, 0);
    endtask

    initial begin
        rst = 1'b1; run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0;
        restart_btn = 1'b0; core_stall = '0;
        tick(2);
        chk("reset_core_rst", core_rst, 1);
        chk("reset_en", core_en, 0);
        chk("reset_state", state, 0);
        chk("reset_cnt", cycle_cnt, 0);
        chk("reset_dl", deadlock, 0);

        // 1: core_rst for two edges after release, then a run press
        rst = 1'b0;
        tick(1);
        chk("t1_core_rst_e1", core_rst, 1);
        tick(1);
        chk("t1_core_rst_e2", core_rst, 0);
        chk("t1_state_idle", state, 0);
        chk("t1_en_idle", core_en, 0);
        run_btn = 1'b1;
        tick(1);
        run_btn = 1'b0;
        chk("t1_run_state", state, 1);
        chk("t1_run_en", core_en, 1);
        halt_btn = 1'b1;
        tick(1);
        halt_btn = 1'b0;
        chk("t1_halt_state", state, 0);
        chk("t1_halt_en", core_en, 0);
        chk("t1_halt_cnt", cycle_cnt, 1);

        // 2: step held for five cycles gives exactly one enabled cycle
        do_restart();
        step_btn = 1'b1;
        tick(1);
        chk("t2_step_state", state, 2);
        chk("t2_step_en", core_en, 1);
        tick(1);
        chk("t2_back_state", state, 0);
        chk("t2_back_en", core_en, 0);
        tick(3);
        step_btn = 1'b0;
        chk("t2_hold_en", core_en, 0);
        chk("t2_cnt1", cycle_cnt, 1);
        chk("t2_final_state", state, 0);
        tick(1);
        step_btn = 1'b1;
        tick(1);
        step_btn = 1'b0;
        tick(1);
        chk("t2_cnt2", cycle_cnt, 2);

        // 3a: deadlock after the 16th enabled stalled cycle
        do_restart();
        core_stall = '1;
        run_btn = 1'b1;
        tick(1);
        run_btn = 1'b0;
        tick(15);
        chk("t3_pre_state", state, 1);
        chk("t3_pre_en", core_en, 1);
        tick(1);
        chk("t3_dl_state", state, 3);
        chk("t3_dl_flag", deadlock, 1);
        chk("t3_dl_en", core_en, 0);
        chk("t3_dl_cnt", cycle_cnt, 16);
        run_btn = 1'b1;
        tick(1);
        run_btn = 1'b0;
        chk("t3_dl_run_ignored", state, 3);
        halt_btn = 1'b1;
        tick(1);
        halt_btn = 1'b0;
        chk("t3_dl_halt_state", state, 0);
        chk("t3_dl_halt_flag", deadlock, 0);

        // 3b: one core unstalls in the 15th cycle, the count starts over
        do_restart();
        run_btn = 1'b1;
        tick(1);
        run_btn = 1'b0;
        tick(14);
        core_stall = 12'hffe;
        tick(1);
        core_stall = '1;
        tick(15);
        chk("t3b_no_dl", state, 1);
        tick(1);
        chk("t3b_late_dl", state, 3);
        chk("t3b_cnt", cycle_cnt, 31);

        // 3c: halt on the triggering edge wins over deadlock
        do_restart();
        run_btn = 1'b1;
        tick(1);
        run_btn = 1'b0;
        tick(15);
        halt_btn = 1'b1;
        tick(1);
        halt_btn = 1'b0;
        core_stall = '0;
        chk("t3c_halt_state", state, 0);
        chk("t3c_halt_dl", deadlock, 0);

        // 4: simultaneous requests
        tick(1);
        run_btn = 1'b1; halt_btn = 1'b1;
        tick(1);
        run_btn = 1'b0; halt_btn = 1'b0;
        chk("t4_halt_over_run", state, 0);
        tick(1);
        run_btn = 1'b1;
        tick(1);
        run_btn = 1'b0;
        chk("t4_running", state, 1);
        tick(3);
        run_btn = 1'b1; restart_btn = 1'b1;
        tick(1);
        run_btn = 1'b0; restart_btn = 1'b0;
        chk("t4_rs_core_rst0", core_rst, 1);
        chk("t4_rs_cnt", cycle_cnt, 0);
        chk("t4_rs_state", state, 0);
        tick(1);
        chk("t4_rs_core_rst1", core_rst, 1);
        tick(1);
        chk("t4_rs_core_rst2", core_rst, 0);
        chk("t4_rs_state2", state, 0);

        // 5: run held through reset needs a release first
        run_btn = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("t5_held_no_run", state, 0);
        chk("t5_held_en", core_en, 0);
        run_btn = 1'b0;
        tick(1);
        run_btn = 1'b1;
        tick(1);
        run_btn = 1'b0;
        chk("t5_repress_run", state, 1);

        // 6: 20 enabled cycles, the 4-bit counter sticks at 15
        tick(20);
        chk("t6_cnt_wide", cycle_cnt, 20);
        chk("t6_cnt_sat", s_cycle_cnt, 15);
        chk("t6_small_state", s_state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
